// File: rtl/mul4_rr_arbiter_if.sv
// Request/result bundle for the shared 4x4 signed multiplier arbiter.
// master = client side, slave = arbiter side.
interface mul4_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_x;
  logic [4*N-1:0] req_y;
  logic           res_valid;
  logic           res_ready;
  logic [7:0]     res_z;
  logic [IDW-1:0] res_id;
  logic           busy;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_z, res_id, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_z, res_id, busy
  );
endinterface

// File: rtl/mul4_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 two's-complement multiplier among N
// requesters; the product lands in a single ID-tagged output register.
module mul4x4s (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);
  // Sign-extended operands multiplied modulo 2^8 give the exact signed product.
  assign z = {{4{x[3]}}, x} * {{4{y[3]}}, y};
endmodule

module mul4_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic               clk,
  input  logic               reset,
  mul4_rr_arbiter_if.slave   bus
);
  localparam logic [IDW:0] NW = (IDW+1)'(N);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           accept;
  logic           xfer;
  logic [N-1:0]   rot;
  logic [N-1:0]   ready;
  logic [IDW:0]   sum;
  logic [IDW:0]   ptr_nxt;
  logic [3:0]     x_sel;
  logic [3:0]     y_sel;
  logic [7:0]     prod;
  logic           res_valid_q;
  logic [7:0]     res_z_q;
  logic [IDW-1:0] res_id_q;

  assign accept = !res_valid_q || bus.res_ready;

  // Rotating the valid vector by ptr turns the circular scan into a
  // first-set-bit search; the offset is then mapped back modulo N.
  always_comb begin
    rot       = N'({bus.req_valid, bus.req_valid} >> ptr);
    gnt_found = 1'b0;
    sum       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        sum       = (IDW+1)'(ptr) + (IDW+1)'(k);
      end
    end
    if (sum >= NW) sum = sum - NW;
    gnt_idx = sum[IDW-1:0];
  end

  always_comb begin
    ready = '0;
    if (!reset && accept && gnt_found) ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_nxt = (IDW+1)'(gnt_idx) + (IDW+1)'(1);
    if (ptr_nxt == NW) ptr_nxt = '0;
  end

  assign xfer  = |ready;
  assign x_sel = bus.req_x[{gnt_idx, 2'b00} +: 4];
  assign y_sel = bus.req_y[{gnt_idx, 2'b00} +: 4];

  mul4x4s u_mul (
    .x (x_sel),
    .y (y_sel),
    .z (prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_z_q     <= '0;
      res_id_q    <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      res_valid_q <= 1'b1;
      res_z_q     <= prod;
      res_id_q    <= gnt_idx;
      ptr         <= ptr_nxt[IDW-1:0];
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_z     = res_z_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = res_valid_q | (|bus.req_valid);
endmodule

// File: tb/tb_mul4_rr_arbiter.sv
// Bench for mul4_rr_arbiter: directed scenarios plus a randomized run
// against a queue-free behavioural model of the arbitration rules.
module tb_mul4_rr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul4_rr_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  mul4_rr_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         m_ptr = 0;
  bit         m_rv  = 1'b0;
  logic [7:0] m_rz  = '0;
  int         m_rid = 0;
  int         last_g = -1;

  function automatic int sx4(logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic logic [7:0] ref_mul(logic [3:0] a, logic [3:0] b);
    int p;
    p = sx4(a) * sx4(b);
    return p[7:0];
  endfunction

  function automatic int model_grant();
    if (reset) return -1;
    if (m_rv && !bus.res_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDW-1:0] id_of(int g);
    return IDW'(g);
  endfunction

  task automatic set_ops(int i, logic [3:0] x, logic [3:0] y);
    bus.req_x[4*i +: 4] = x;
    bus.req_y[4*i +: 4] = y;
  endtask

  // Advance one clock edge and move the model in step with it.
  task automatic tick();
    int         g;
    logic [3:0] gx, gy;
    bit         drain, rst;
    g     = model_grant();
    drain = m_rv && bus.res_ready;
    rst   = reset;
    gx    = '0;
    gy    = '0;
    if (g >= 0) begin
      gx = bus.req_x[4*g +: 4];
      gy = bus.req_y[4*g +: 4];
    end
    @(posedge clk);
    if (rst) begin
      m_rv = 1'b0; m_rz = '0; m_rid = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_rv = 1'b1; m_rz = ref_mul(gx, gy); m_rid = g; m_ptr = (g + 1) % N;
    end else if (drain) begin
      m_rv = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_cmp++; if (bus.res_z !== 8'h00) begin n_err++; $display("FAIL reset_res_z: got %h want 00", bus.res_z); end
    n_cmp++; if (bus.res_id !== 2'd0) begin n_err++; $display("FAIL reset_res_id: got %0d want 0", bus.res_id); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0010;
    set_ops(1, 4'h3, 4'h5);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL single_res_valid: got %b want 1", bus.res_valid); end
    n_cmp++; if (bus.res_z !== 8'h0F) begin n_err++; $display("FAIL single_res_z: got %h want 0f", bus.res_z); end
    n_cmp++; if (bus.res_id !== 2'd1) begin n_err++; $display("FAIL single_res_id: got %0d want 1", bus.res_id); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_drop: got %b want 0000", bus.req_ready); end
    tick();
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", bus.res_valid); end
  endtask

  task automatic test_corner();
    logic [3:0] cx [4] = '{4'h8, 4'h8, 4'hF, 4'h0};
    logic [3:0] cy [4] = '{4'h8, 4'h7, 4'hF, 4'h9};
    logic [7:0] cz [4] = '{8'h40, 8'hC8, 8'h01, 8'h00};
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_ops(0, cx[i], cy[i]);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL corner_ready[%0d]: got %b want 0001", i, bus.req_ready); end
      tick();
      n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL corner_valid[%0d]: got %b want 1", i, bus.res_valid); end
      n_cmp++; if (bus.res_z !== cz[i]) begin n_err++; $display("FAIL corner_z[%0d]: got %h want %h", i, bus.res_z, cz[i]); end
      n_cmp++; if (bus.res_id !== 2'd0) begin n_err++; $display("FAIL corner_id[%0d]: got %0d want 0", i, bus.res_id); end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 4'($urandom), 4'($urandom));
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_cmp++; if (bus.req_ready !== onehot(c % N)) begin n_err++; $display("FAIL fair_grant[%0d]: got %b want %b", c, bus.req_ready, onehot(c % N)); end
      tick();
      n_cmp++; if (bus.res_id !== id_of(c % N)) begin n_err++; $display("FAIL fair_id[%0d]: got %0d want %0d", c, bus.res_id, c % N); end
      n_cmp++; if (bus.res_z !== m_rz) begin n_err++; $display("FAIL fair_z[%0d]: got %h want %h", c, bus.res_z, m_rz); end
      set_ops(c % N, 4'($urandom), 4'($urandom));
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    set_ops(0, 4'h6, 4'hD);
    tick();
    held = 8'hEE;  // 6 * -3 = -18
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1100;
    set_ops(2, 4'h2, 4'h2);
    set_ops(3, 4'h7, 4'h7);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, bus.req_ready); end
      tick();
      n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.res_valid); end
      n_cmp++; if (bus.res_z !== held) begin n_err++; $display("FAIL bp_z[%0d]: got %h want %h", c, bus.res_z, held); end
      n_cmp++; if (bus.res_id !== 2'd0) begin n_err++; $display("FAIL bp_id[%0d]: got %0d want 0", c, bus.res_id); end
    end
    bus.res_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_resume: got %b want 0100", bus.req_ready); end
    tick();
    n_cmp++; if (bus.res_z !== 8'h04 || bus.res_id !== 2'd2) begin n_err++; $display("FAIL bp_resume_res: got %h/%0d want 04/2", bus.res_z, bus.res_id); end
    bus.req_valid = 4'b1000;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_next: got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_skip();
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0010;
    set_ops(1, 4'h1, 4'h1);
    tick();
    bus.req_valid = 4'b1010;
    set_ops(1, 4'h2, 4'h3);
    set_ops(3, 4'hF, 4'h4);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL skip_first: got %b want 1000", bus.req_ready); end
    tick();
    n_cmp++; if (bus.res_id !== 2'd3 || bus.res_z !== 8'hFC) begin n_err++; $display("FAIL skip_res3: got %0d/%h want 3/fc", bus.res_id, bus.res_z); end
    bus.req_valid = 4'b0010;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL skip_second: got %b want 0010", bus.req_ready); end
    tick();
    n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_z !== 8'h06) begin
      n_err++; $display("FAIL skip_res1: got %b/%0d/%h want 1/1/06", bus.res_valid, bus.res_id, bus.res_z);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0110;
    set_ops(1, 4'h5, 4'h3);
    set_ops(2, 4'h3, 4'h3);
    #1;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_ready: got %b want 0000", bus.req_ready); end
    tick();
    n_cmp++; if (bus.res_valid !== 1'b0 || bus.res_z !== 8'h00) begin n_err++; $display("FAIL rmid_res: got %b/%h want 0/00", bus.res_valid, bus.res_z); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rmid_regrant: got %b want 0010", bus.req_ready); end
    tick();
    n_cmp++; if (bus.res_id !== 2'd1 || bus.res_z !== 8'h0F) begin n_err++; $display("FAIL rmid_res1: got %0d/%h want 1/0f", bus.res_id, bus.res_z); end
    bus.req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && ($urandom % 3) == 0) begin
          bus.req_valid[i] = 1'b1;
          set_ops(i, 4'($urandom), 4'($urandom));
        end
      end
      bus.res_ready = ($urandom % 4) != 0;
      reset = ($urandom % 64) == 0;
      #1;
      exp_rdy = onehot(model_grant());
      n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
      n_cmp++; if (bus.busy !== (m_rv | (|bus.req_valid))) begin n_err++; $display("FAIL rand_busy[%0d]: got %b want %b", c, bus.busy, m_rv | (|bus.req_valid)); end
      tick();
      n_cmp++; if (bus.res_valid !== m_rv) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.res_valid, m_rv); end
      n_cmp++; if (bus.res_z !== m_rz) begin n_err++; $display("FAIL rand_z[%0d]: got %h want %h", c, bus.res_z, m_rz); end
      n_cmp++; if (bus.res_id !== id_of(m_rid)) begin n_err++; $display("FAIL rand_id[%0d]: got %0d want %0d", c, bus.res_id, m_rid); end
      if (last_g >= 0) begin
        bus.req_valid[last_g] = 1'($urandom % 2);
        if (bus.req_valid[last_g]) set_ops(last_g, 4'($urandom), 4'($urandom));
      end
    end
    reset = 1'b0;
    bus.req_valid = '0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single();
    test_corner();
    test_fairness();
    test_backpressure();
    test_skip();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul4_rr_arbiter.md
Name: mul4_rr_arbiter

Overview:
- Shares one 4x4 two's-complement array multiplier between N requesters.
- Each requester presents a signed operand pair, with X and Y each 4 bits, over a valid/ready handshake.
- Arbitration is round-robin.
- The granted pair goes through the combinational multiplier and lands in a single output register. The register is tagged with the requester ID and drained over its own valid/ready handshake.
- Sits between several small DSP/control clients and the shared multiplier instance, which is instantiated inside this block.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID. Must satisfy 2^IDW >= N.

Ports:
- clk  input  1  clock. Rising edge is active.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N  per-requester request valid.
- req_ready  output  N  per-requester grant/accept. One-hot or zero.
- req_x  input  4*N  multiplicand for requester i, in bits [4i+3:4i], two's complement.
- req_y  input  4*N  multiplier for requester i, in bits [4i+3:4i], two's complement.
- res_valid  output  1  result register holds an undelivered product.
- res_ready  input  1  consumer accepts the result.
- res_z  output  8  signed product X*Y, two's complement.
- res_id  output  IDW  index of the requester that produced res_z.
- busy  output  1  res_valid OR any req_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - res_valid=0, res_z=0, res_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - req_ready=0 while reset is high.
- Accept condition: accept = !res_valid | res_ready. The output register can load in the same cycle it drains.
- Arbitration (combinational):
  - When accept=1, grant the first requester with req_valid=1, scanning ptr, ptr+1, ..., N-1, 0, ... ptr-1 (modulo N).
  - req_ready[g]=1 for the granted g only. All other req_ready bits are 0.
  - When accept=0 or no req_valid, req_ready=0.
- Handshake:
  - A transfer occurs on a clk edge where req_valid[i] & req_ready[i].
  - A requester holds valid and operands stable until it is granted.
  - req_ready never depends on the requester's own operands.
- Datapath:
  - mux(req_x[g], req_y[g]) feeds the internal multiplier.
  - On transfer: res_z <= X*Y, full 8-bit signed result with no saturation; res_id <= g; res_valid <= 1.
- Latency: a grant in cycle t gives res_valid=1 in cycle t+1. Throughput is one product per cycle while res_ready=1.
- Result register with no new transfer:
  - If res_valid & res_ready, then res_valid <= 0.
  - res_z and res_id hold their last values.
- Backpressure: if res_valid=1 and res_ready=0, then req_ready=0 for all requesters and res_z/res_id/res_valid are held stable.
- Pointer update: on each transfer, ptr <= (g+1) mod N. With no transfer, ptr holds.
- Fairness: with all N requesters asserting continuously and res_ready=1, each requester is served exactly once per N consecutive grants.
- Arithmetic boundaries:
  - (-8)*(-8) = +64 = 8'h40. This is the only case needing bit 6; it must not overflow.
  - (-8)*7 = -56 = 8'hC8.
  - Any operand of 0 gives 8'h00.
- Reset mid-operation: a pending result is discarded (res_valid=0), the pointer returns to 0, and no grant is issued in the reset cycle. Requesters that were not granted keep their requests and are re-arbitrated from requester 0.
- Simultaneous drain and grant: both happen on the same edge. The new result replaces the old one with no bubble.

Test Plan:
- Single requester 1, X=4'h3, Y=4'h5, res_ready=1 → req_ready[1]=1 for one cycle; next cycle res_valid=1, res_z=8'h0F, res_id=1.
- Corner products via requester 0, pairs (8,8), (8,7), (F,F), (0,9) → res_z = 8'h40, 8'hC8, 8'h01, 8'h00 in consecutive cycles. No bubbles.
- All 4 requesters valid continuously after reset, res_ready=1 → grant order 0,1,2,3,0,1,... and res_id sequence matches one cycle later.
- Result pending with res_ready=0 for 3 cycles while requesters 2 and 3 are valid → req_ready=0 and res_z/res_id stable. When res_ready rises, the next grant goes to the requester after the last grantee.
- Requesters 1 and 3 valid with ptr=2 → 3 is granted first, then 1. Requester 3 drops valid after its grant → requester 1 is granted alone with no idle cycle.
- reset asserted while res_valid=1 and requesters are valid → next cycle res_valid=0, req_ready=0. After reset deasserts, the first grant goes to the lowest-index valid requester.
